alu_op_sequencer: RTL and testbench

Sequential command front-end for the combinational 4-bit ALU. It accepts one operation (A, B, op) at a time over a valid/ready command channel and drives the registered operands into the ALU. It waits a fixed settle interval, samples the 5-bit ALU result, and returns it over a valid/ready response channel. It replaces free-running delay-based stimulus with a handshaked master, so a controller or bench can issue ALU operations at any rate and collect results without racing the datapath.

---
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Handshaked command front-end for a combinational 4-bit ALU. One operation
// (A, B, op) is accepted at a time. The operands are registered and driven to
// the ALU. After SETTLE_CYCLES edges the 5-bit ALU result is sampled, and it is
// returned over a valid/ready response channel.
//
// Parameters
//   SETTLE_CYCLES : edges between operand launch and result sample (1..15)
//   COUNT_W       : width of the completed-transaction counter
//
// Ports
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake
//   cmd_a, cmd_b, cmd_op    : command operands and opcode
//   alu_a, alu_b, alu_op    : registered operands and opcode driven to the ALU
//   alu_result              : combinational ALU result (5 bits)
//   rsp_valid / rsp_ready   : response handshake
//   rsp_result, rsp_op      : captured result and the opcode that produced it
//   busy                    : high whenever the sequencer is not idle
//   txn_count               : completed responses, wraps modulo 2^COUNT_W
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic [3:0]         cmd_op,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_op,
  input  logic [4:0]         alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [4:0]         rsp_result,
  output logic [3:0]         rsp_op,
  output logic               busy,
  output logic [COUNT_W-1:0] txn_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so that the sample happens on
  // the edge where it reads zero, i.e. exactly SETTLE_CYCLES edges after the
  // accept edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         alu_a_q, alu_a_d;
  logic [3:0]         alu_b_q, alu_b_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [4:0]         rsp_result_q, rsp_result_d;
  logic [3:0]         rsp_op_q, rsp_op_d;
  logic [COUNT_W-1:0] txn_count_q, txn_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      txn_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      txn_count_q  <= txn_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    txn_count_d  = txn_count_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is 1 in IDLE, so cmd_valid alone completes the handshake.
        if (cmd_valid) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          cnt_d    = SETTLE_LOAD;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + COUNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from state alone: no input-to-output paths.
  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Two instances share clock, reset and the
// command/response stimulus. sel3 routes the handshakes either to the
// SETTLE_CYCLES=1 / COUNT_W=4 instance or to the SETTLE_CYCLES=3 instance.
// Each instance has its own adder model for the ALU.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel3 = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic       rsp_ready = 1'b0;

  always #5 clk = ~clk;

  // instance 1: SETTLE_CYCLES=1, COUNT_W=4
  logic       d1_cmd_ready, d1_rsp_valid, d1_busy;
  logic [3:0] d1_alu_a, d1_alu_b, d1_alu_op, d1_rsp_op, d1_txn;
  logic [4:0] d1_alu_result, d1_rsp_result;
  assign d1_alu_result = {1'b0, d1_alu_a} + {1'b0, d1_alu_b};

  alu_op_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid & ~sel3), .cmd_ready(d1_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
    .alu_result(d1_alu_result),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready & ~sel3),
    .rsp_result(d1_rsp_result), .rsp_op(d1_rsp_op),
    .busy(d1_busy), .txn_count(d1_txn)
  );

  // instance 2: SETTLE_CYCLES=3, COUNT_W=16
  logic        d3_cmd_ready, d3_rsp_valid, d3_busy;
  logic [3:0]  d3_alu_a, d3_alu_b, d3_alu_op, d3_rsp_op;
  logic [4:0]  d3_alu_result, d3_rsp_result;
  logic [15:0] d3_txn;
  assign d3_alu_result = {1'b0, d3_alu_a} + {1'b0, d3_alu_b};

  alu_op_sequencer #(.SETTLE_CYCLES(3), .COUNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid & sel3), .cmd_ready(d3_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
    .alu_result(d3_alu_result),
    .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready & sel3),
    .rsp_result(d3_rsp_result), .rsp_op(d3_rsp_op),
    .busy(d3_busy), .txn_count(d3_txn)
  );

  // view of whichever instance is selected
  logic        cur_cmd_ready, cur_rsp_valid;
  logic [3:0]  cur_rsp_op;
  logic [4:0]  cur_rsp_result;
  logic [15:0] cur_txn;
  assign cur_cmd_ready  = sel3 ? d3_cmd_ready  : d1_cmd_ready;
  assign cur_rsp_valid  = sel3 ? d3_rsp_valid  : d1_rsp_valid;
  assign cur_rsp_op     = sel3 ? d3_rsp_op     : d1_rsp_op;
  assign cur_rsp_result = sel3 ? d3_rsp_result : d1_rsp_result;
  assign cur_txn        = sel3 ? d3_txn        : {12'd0, d1_txn};

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {op, result}
  int exp_txn = 0;        // model of instance 1 txn_count (before wrap)

  // Present a command and return #1 after its accept edge; pushes the
  // expected response onto the scoreboard.
  task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n;
    logic [4:0] r;
    n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (!cur_cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r = {1'b0, a} + {1'b0, b};
    exp_q.push_back({op, r});
  endtask

  // Count edges from the accept until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!cur_rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d1_alu_a, d1_alu_b, d1_alu_op} !== 12'd0) begin
      failures++; $display("FAIL reset_alu got=%h exp=000", {d1_alu_a, d1_alu_b, d1_alu_op});
    end
    checks++;
    if ({d1_rsp_result, d1_rsp_op} !== 9'd0) begin
      failures++; $display("FAIL reset_rsp got=%h exp=000", {d1_rsp_result, d1_rsp_op});
    end
    checks++;
    if ({d1_rsp_valid, d1_busy} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_busy got=%b exp=00", {d1_rsp_valid, d1_busy});
    end
    checks++;
    if (d1_txn !== 4'd0) begin
      failures++; $display("FAIL reset_txn got=%0d exp=0", d1_txn);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({d1_cmd_ready, d3_cmd_ready} !== 2'b11) begin
      failures++; $display("FAIL reset_cmd_ready got=%b exp=11", {d1_cmd_ready, d3_cmd_ready});
    end
    exp_txn = 0;
    $display("reset: txn_count=%0d cmd_ready=%b", d1_txn, d1_cmd_ready);
  endtask

  task automatic test_single;
    int lat;
    logic [8:0] e;
    rsp_ready = 1'b1;
    send_cmd(4'd9, 4'd11, 4'b1000);
    checks++;
    if ({d1_alu_a, d1_alu_b, d1_alu_op} !== {4'd9, 4'd11, 4'b1000}) begin
      failures++; $display("FAIL single_alu got=%h exp=9b8", {d1_alu_a, d1_alu_b, d1_alu_op});
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL single_latency got=%0d exp=1", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({cur_rsp_op, cur_rsp_result} !== e) begin
      failures++; $display("FAIL single_rsp got=%h exp=%h", {cur_rsp_op, cur_rsp_result}, e);
    end
    @(posedge clk); #1;
    exp_txn++;
    checks++;
    if ({d1_rsp_valid, d1_cmd_ready, d1_txn} !== {2'b01, 4'(exp_txn)}) begin
      failures++; $display("FAIL single_done got=%b_%b_%0d exp=0_1_%0d", d1_rsp_valid, d1_cmd_ready, d1_txn, exp_txn);
    end
    $display("single: a=9 b=11 result=%0d op=%b lat=%0d txn=%0d", d1_rsp_result, d1_rsp_op, lat, d1_txn);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [8:0] e;
    rsp_ready = 1'b0;
    send_cmd(4'd2, 4'd2, 4'd3);
    wait_rsp(lat);
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL bp_latency got=%0d exp=1", lat);
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      cmd_valid = (k == 2); cmd_a = 4'd7; cmd_b = 4'd7; cmd_op = 4'd7;
      @(posedge clk); #1;
      checks++;
      if ({d1_rsp_valid, d1_cmd_ready, d1_rsp_op, d1_rsp_result} !== {2'b10, e}) begin
        failures++; $display("FAIL bp_hold cycle=%0d got=%b_%b_%h exp=1_0_%h", k, d1_rsp_valid, d1_cmd_ready, {d1_rsp_op, d1_rsp_result}, e);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (d1_alu_a !== 4'd2) begin
      failures++; $display("FAIL bp_cmd_ignored got=%0d exp=2", d1_alu_a);
    end
    // command and response-ready together in RESP: only the response completes
    cmd_valid = 1'b1; cmd_a = 4'd5; cmd_b = 4'd6; cmd_op = 4'd9;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_txn++;
    checks++;
    if ({d1_rsp_valid, d1_cmd_ready, d1_alu_a, d1_txn} !== {2'b01, 4'd2, 4'(exp_txn)}) begin
      failures++; $display("FAIL bp_collision got=%b_%b_%0d_%0d exp=0_1_2_%0d", d1_rsp_valid, d1_cmd_ready, d1_alu_a, d1_txn, exp_txn);
    end
    $display("backpressure: held result=%0d, txn=%0d", e[4:0], d1_txn);
    send_cmd(4'd5, 4'd6, 4'd9);
    checks++;
    if (d1_alu_a !== 4'd5) begin
      failures++; $display("FAIL bp_late_accept got=%0d exp=5", d1_alu_a);
    end
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++;
    if ({cur_rsp_op, cur_rsp_result} !== e) begin
      failures++; $display("FAIL bp_late_rsp got=%h exp=%h", {cur_rsp_op, cur_rsp_result}, e);
    end
    @(posedge clk); #1;
    exp_txn++;
    checks++;
    if (d1_txn !== 4'(exp_txn)) begin
      failures++; $display("FAIL bp_txn got=%0d exp=%0d", d1_txn, exp_txn);
    end
    $display("backpressure: late op a=5 b=6 result=%0d txn=%0d", e[4:0], d1_txn);
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [8:0] e;
    rsp_ready = 1'b1;
    send_cmd(4'd4, 4'd5, 4'd1);
    exp_q.delete();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({d1_rsp_valid, d1_busy, d1_cmd_ready, d1_alu_a, d1_alu_b, d1_txn} !== {3'b001, 12'd0}) begin
      failures++; $display("FAIL mid_reset got=%b_%b_%b_%0d_%0d_%0d exp=0_0_1_0_0_0", d1_rsp_valid, d1_busy, d1_cmd_ready, d1_alu_a, d1_alu_b, d1_txn);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (d1_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL mid_no_rsp cycle=%0d got=%b exp=0", k, d1_rsp_valid);
      end
    end
    rst_n = 1'b1;
    exp_txn = 0;
    @(posedge clk); #1;
    send_cmd(4'd3, 4'd0, 4'd2);
    wait_rsp(lat);
    e = exp_q.pop_front();
    checks++;
    if ({cur_rsp_op, cur_rsp_result, lat} !== {e, 32'd1}) begin
      failures++; $display("FAIL mid_after_rsp got=%h lat=%0d exp=%h lat=1", {cur_rsp_op, cur_rsp_result}, lat, e);
    end
    @(posedge clk); #1;
    exp_txn++;
    checks++;
    if (d1_txn !== 4'(exp_txn)) begin
      failures++; $display("FAIL mid_txn got=%0d exp=%0d", d1_txn, exp_txn);
    end
    $display("reset_mid: after release a=3 b=0 result=%0d txn=%0d", e[4:0], d1_txn);
  endtask

  task automatic test_settle;
    int lat;
    logic [8:0] e;
    sel3 = 1'b1;
    rsp_ready = 1'b1;
    send_cmd(4'd15, 4'd15, 4'd5);
    lat = 0;
    while (!cur_rsp_valid && lat < 50) begin
      checks++;
      if ({d3_alu_a, d3_alu_b, d3_alu_op} !== {4'd15, 4'd15, 4'd5}) begin
        failures++; $display("FAIL settle_alu_stable got=%h exp=ff5", {d3_alu_a, d3_alu_b, d3_alu_op});
      end
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat !== 3) begin
      failures++; $display("FAIL settle_latency got=%0d exp=3", lat);
    end
    e = exp_q.pop_front();
    checks++;
    if ({cur_rsp_op, cur_rsp_result} !== e) begin
      failures++; $display("FAIL settle_rsp got=%h exp=%h", {cur_rsp_op, cur_rsp_result}, e);
    end
    @(posedge clk); #1;
    checks++;
    if ({d3_rsp_valid, d3_cmd_ready, d3_txn} !== {2'b01, 16'd1}) begin
      failures++; $display("FAIL settle_done got=%b_%b_%0d exp=0_1_1", d3_rsp_valid, d3_cmd_ready, d3_txn);
    end
    $display("settle: a=15 b=15 result=%0d lat=%0d txn=%0d", e[4:0], lat, d3_txn);
    sel3 = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc, issued, got, last_acc;
    logic accept_now;
    logic [8:0] e;
    logic [4:0] r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cyc = 0; issued = 0; got = 0; last_acc = 0;
    cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 4'd6;
    while (got < 16 && cyc < 200) begin
      cmd_valid = (issued < 16);
      accept_now = d1_cmd_ready && (issued < 16);
      if (accept_now) begin
        r = {1'b0, cmd_a} + {1'b0, cmd_b};
        exp_q.push_back({cmd_op, r});
      end
      if (d1_rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_unexpected_rsp got=%h", {d1_rsp_op, d1_rsp_result});
        end else begin
          e = exp_q.pop_front();
          if ({d1_rsp_op, d1_rsp_result} !== e) begin
            failures++; $display("FAIL stream_rsp idx=%0d got=%h exp=%h", got, {d1_rsp_op, d1_rsp_result}, e);
          end
        end
        checks++;
        if (d1_txn !== 4'(got % 16)) begin
          failures++; $display("FAIL stream_txn idx=%0d got=%0d exp=%0d", got, d1_txn, got % 16);
        end
        $display("stream: rsp %0d result=%0d txn=%0d", got, d1_rsp_result, d1_txn);
        got++;
      end
      @(posedge clk); #1; cyc++;
      if (accept_now) begin
        if (issued > 0) begin
          checks++;
          if (cyc - last_acc !== 3) begin
            failures++; $display("FAIL stream_interval idx=%0d got=%0d exp=3", issued, cyc - last_acc);
          end
        end
        last_acc = cyc;
        issued++;
        cmd_a = 4'(issued); cmd_b = 4'(issued);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (got !== 16) begin
      failures++; $display("FAIL stream_timeout got=%0d responses exp=16", got);
    end
    checks++;
    if ({d1_txn, d1_cmd_ready} !== {4'd0, 1'b1}) begin
      failures++; $display("FAIL stream_wrap got=%0d_%b exp=0_1", d1_txn, d1_cmd_ready);
    end
    $display("stream: %0d responses, txn after wrap=%0d", got, d1_txn);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_settle();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
